// File: rtl/breakout_pkg.sv
// Shared constants for the breakout design: game FSM encoding and BCD digit geometry.
package breakout_pkg;

  typedef enum logic [1:0] {
    ST_NEWGAME = 2'b00,
    ST_PLAY    = 2'b01,
    ST_NEWBALL = 2'b10,
    ST_OVER    = 2'b11
  } game_state_e;

  localparam int BCD_W      = 4;
  localparam int BCD_DIGITS = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_counter4.sv
// 4-digit BCD incrementer: sync clear, increment enable, saturates at 9999.
module bcd_counter4
  import breakout_pkg::*;
(
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        clr,
  input  logic                        inc,
  output logic [BCD_DIGITS*BCD_W-1:0] bcd
);

  logic [BCD_DIGITS-1:0] nine;   // digit currently reads 9
  logic [BCD_DIGITS-1:0] carry;  // digit advances this cycle
  logic                  sat;

  assign sat      = &nine;
  assign carry[0] = inc & ~sat;

  for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_dig
    logic [BCD_W-1:0] d_q;

    assign nine[i]                 = (d_q == BCD_MAX);
    assign bcd[i*BCD_W +: BCD_W]   = d_q;

    if (i < BCD_DIGITS-1) begin : g_cy
      assign carry[i+1] = carry[i] & nine[i];
    end

    // Per-digit register; a 9 rolls to 0 and ripples into the next digit.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)          d_q <= '0;
      else if (clr)       d_q <= '0;
      else if (carry[i])  d_q <= nine[i] ? '0 : d_q + 1'b1;
    end
  end

endmodule

// File: rtl/breakout_game_ctrl.sv
// Breakout game-flow controller: newgame/play/newball/over FSM, score, high score, balls.
module breakout_game_ctrl
  import breakout_pkg::*;
#(
  parameter int BALLS        = 3,
  parameter int DELAY_CYCLES = 200_000_000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start_key,
  input  logic        hit,
  input  logic        miss,
  output logic        gra_still,
  output logic        game_reset,
  output logic [1:0]  state,
  output logic [1:0]  balls,
  output logic [15:0] score_bcd,
  output logic [15:0] hi_bcd,
  output logic [31:0] seg_data
);

  localparam int             TW         = (DELAY_CYCLES > 2) ? $clog2(DELAY_CYCLES) : 1;
  localparam logic [TW-1:0]  T_LOAD     = TW'(DELAY_CYCLES - 1);
  localparam logic [1:0]     BALLS_INIT = 2'(BALLS);

  logic        hit_q, miss_q, start_q;
  logic        hit_ev, miss_ev, start_ev;
  game_state_e st_q, st_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [1:0]  balls_q, balls_d;
  logic [15:0] hi_q, hi_d;
  logic        grst_q, grst_d;
  logic        sc_clr, sc_inc, start_game;
  logic [15:0] score;

  assign hit_ev   = hit       & ~hit_q;
  assign miss_ev  = miss      & ~miss_q;
  assign start_ev = start_key & ~start_q;

  // Input history for rising-edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      hit_q   <= hit;
      miss_q  <= miss;
      start_q <= start_key;
    end
  end

  bcd_counter4 u_score (
    .clk  (clk),
    .rstn (rstn),
    .clr  (sc_clr),
    .inc  (sc_inc),
    .bcd  (score)
  );

  // Next-state, timer, balls and high-score decisions.
  always_comb begin
    st_d       = st_q;
    tmr_d      = tmr_q;
    balls_d    = balls_q;
    hi_d       = hi_q;
    grst_d     = 1'b0;
    sc_clr     = 1'b0;
    sc_inc     = 1'b0;
    start_game = 1'b0;
    unique case (st_q)
      ST_NEWGAME: start_game = start_ev;
      ST_PLAY: begin
        sc_inc = hit_ev;
        if (miss_ev) begin
          tmr_d = T_LOAD;
          if (balls_q > 2'd1) begin
            balls_d = balls_q - 2'd1;
            st_d    = ST_NEWBALL;
          end else begin
            balls_d = 2'd0;
            st_d    = ST_OVER;
          end
        end
      end
      ST_NEWBALL: begin
        if (tmr_q == '0) st_d  = ST_PLAY;
        else             tmr_d = tmr_q - 1'b1;
      end
      ST_OVER: begin
        // Score is frozen in OVER, so comparing every cycle equals an entry-only
        // update. BCD digits order the same as binary, so unsigned compare works.
        if (score > hi_q) hi_d = score;
        if (tmr_q == '0) start_game = start_ev;
        else             tmr_d      = tmr_q - 1'b1;
      end
      default: st_d = ST_NEWGAME;
    endcase
    if (start_game) begin
      sc_clr  = 1'b1;
      balls_d = BALLS_INIT;
      grst_d  = 1'b1;
      st_d    = ST_PLAY;
    end
  end

  // FSM state and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q    <= ST_NEWGAME;
      tmr_q   <= '0;
      balls_q <= BALLS_INIT;
      hi_q    <= '0;
      grst_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      tmr_q   <= tmr_d;
      balls_q <= balls_d;
      hi_q    <= hi_d;
      grst_q  <= grst_d;
    end
  end

  assign gra_still  = (st_q != ST_PLAY);
  assign game_reset = grst_q;
  assign state      = st_q;
  assign balls      = balls_q;
  assign score_bcd  = score;
  assign hi_bcd     = hi_q;
  assign seg_data   = {hi_q, score};

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// Scoreboard bench for breakout_game_ctrl with a decimal reference model.
module tb_breakout_game_ctrl;

  localparam int D = 8;
  localparam int B = 3;

  logic        clk = 1'b0, rstn = 1'b0;
  logic        start_key = 1'b0, hit = 1'b0, miss = 1'b0;
  logic        gra_still, game_reset;
  logic [1:0]  state, balls;
  logic [15:0] score_bcd, hi_bcd;
  logic [31:0] seg_data;

  breakout_game_ctrl #(.BALLS(B), .DELAY_CYCLES(D)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start_key  (start_key),
    .hit        (hit),
    .miss       (miss),
    .gra_still  (gra_still),
    .game_reset (game_reset),
    .state      (state),
    .balls      (balls),
    .score_bcd  (score_bcd),
    .hi_bcd     (hi_bcd),
    .seg_data   (seg_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  st;
    logic [1:0]  balls;
    logic [15:0] score;
    logic [15:0] hi;
    logic        still;
    logic        grst;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  int m_st, m_balls, m_score, m_hi, m_tmr;
  bit m_grst, ph, pm, ps;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_balls = B; m_score = 0; m_hi = 0; m_tmr = 0;
    m_grst = 0; ph = 0; pm = 0; ps = 0;
  endtask

  // Reference behaviour for one clock edge with the given input levels.
  task automatic model_step(input bit h, input bit m, input bit s);
    bit he, me, se, go;
    exp_t e;
    he = h && !ph; me = m && !pm; se = s && !ps; go = 0;
    ph = h; pm = m; ps = s;
    m_grst = 0;
    case (m_st)
      0: go = se;
      1: begin
        if (he && m_score < 9999) m_score++;
        if (me) begin
          m_tmr = D - 1;
          if (m_balls > 1) begin m_balls--; m_st = 2; end
          else begin m_balls = 0; m_st = 3; end
        end
      end
      2: if (m_tmr == 0) m_st = 1; else m_tmr--;
      default: begin
        if (m_score > m_hi) m_hi = m_score;
        if (m_tmr == 0) go = se; else m_tmr--;
      end
    endcase
    if (go) begin
      m_score = 0; m_balls = B; m_grst = 1; m_st = 1;
    end
    e.st = 2'(m_st); e.balls = 2'(m_balls);
    e.score = to_bcd(m_score); e.hi = to_bcd(m_hi);
    e.still = (m_st != 1); e.grst = m_grst;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    chk("sb_depth", 32'(sb.size()), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("state",      32'(state),      32'(e.st));
      chk("balls",      32'(balls),      32'(e.balls));
      chk("score",      32'(score_bcd),  32'(e.score));
      chk("hi",         32'(hi_bcd),     32'(e.hi));
      chk("gra_still",  32'(gra_still),  32'(e.still));
      chk("game_reset", 32'(game_reset), 32'(e.grst));
      chk("seg_data",   seg_data,        {e.hi, e.score});
    end
  endtask

  // Drive one cycle of inputs, predict, clock, compare.
  task automatic cyc(input bit h, input bit m, input bit s);
    hit = h; miss = m; start_key = s;
    model_step(h, m, s);
    @(posedge clk); #1;
    check_out();
  endtask

  task automatic hits(input int n);
    repeat (n) begin cyc(1, 0, 0); cyc(0, 0, 0); end
  endtask

  task automatic miss_wait();
    cyc(0, 1, 0);
    repeat (D + 1) cyc(0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_still", 32'(gra_still), 32'd1);
    chk("rst_grst",  32'(game_reset), 32'd0);
    chk("rst_balls", 32'(balls), 32'(B));
    chk("rst_seg",   seg_data, 32'h0);
    @(negedge clk) rstn = 1'b1;
    cyc(0, 0, 0);

    // Game 1: start, hits, held hit, newball hold, game over at 42.
    cyc(0, 0, 1);
    chk("start_grst",  32'(game_reset), 32'd1);
    chk("start_state", 32'(state), 32'd1);
    chk("start_balls", 32'(balls), 32'd3);
    chk("start_still", 32'(gra_still), 32'd0);
    cyc(0, 0, 0);
    chk("grst_width", 32'(game_reset), 32'd0);
    hits(12);
    chk("score_12", 32'(score_bcd), 32'h0012);
    repeat (50) cyc(1, 0, 0);
    cyc(0, 0, 0);
    chk("held_hit", 32'(score_bcd), 32'h0013);

    cyc(0, 1, 0);
    chk("nb_state", 32'(state), 32'd2);
    chk("nb_balls", 32'(balls), 32'd2);
    cnt = 1;
    for (int i = 0; i < 20 && gra_still; i++) begin
      cyc(i == 2, 0, i == 4);
      if (gra_still) cnt++;
    end
    chk("nb_len",   32'(cnt), 32'(D));
    chk("nb_play",  32'(state), 32'd1);
    chk("nb_score", 32'(score_bcd), 32'h0013);

    hits(29);
    chk("score_42", 32'(score_bcd), 32'h0042);
    miss_wait();
    cyc(0, 1, 0);
    chk("over_state", 32'(state), 32'd3);
    chk("over_balls", 32'(balls), 32'd0);
    cyc(0, 0, 0);
    chk("hi_42", 32'(hi_bcd), 32'h0042);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    chk("early_start", 32'(state), 32'd3);
    repeat (D) cyc(0, 0, 0);
    cyc(0, 0, 1);
    chk("restart_state", 32'(state), 32'd1);
    chk("restart_score", 32'(score_bcd), 32'h0000);
    chk("restart_hi",    32'(hi_bcd), 32'h0042);

    // Game 2: ends at 17 via simultaneous hit+miss on last ball.
    cyc(0, 0, 0);
    hits(16);
    miss_wait();
    miss_wait();
    cyc(1, 1, 0);
    chk("hm_state", 32'(state), 32'd3);
    chk("hm_score", 32'(score_bcd), 32'h0017);
    cyc(0, 0, 0);
    chk("hi_keep", 32'(hi_bcd), 32'h0042);
    repeat (D + 2) cyc(0, 0, 0);
    cyc(0, 0, 1);
    chk("g3_state", 32'(state), 32'd1);
    cyc(0, 0, 0);

    // Game 3: saturation at 9999.
    hits(9998);
    chk("score_9998", 32'(score_bcd), 32'h9998);
    hits(3);
    chk("score_sat", 32'(score_bcd), 32'h9999);

    // Asynchronous reset mid-PLAY.
    rstn = 1'b0;
    #2;
    chk("mrst_state", 32'(state), 32'd0);
    chk("mrst_still", 32'(gra_still), 32'd1);
    chk("mrst_grst",  32'(game_reset), 32'd0);
    chk("mrst_balls", 32'(balls), 32'(B));
    chk("mrst_score", 32'(score_bcd), 32'h0);
    chk("mrst_hi",    32'(hi_bcd), 32'h0);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    model_reset();
    @(negedge clk) rstn = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/breakout_game_ctrl.md
# breakout_game_ctrl

Game-flow controller for the breakout design: sits downstream of the `pong_graph` playfield and keyboard decoder and upstream of the seven-segment and LED displays. It consumes the playfield's `hit`/`miss` events and a start key. It runs the newgame/play/newball/over state machine, freezes the playfield between balls, and keeps a 4-digit BCD score, a BCD high score and a balls-remaining count. It outputs 32-bit seven-segment data.

## Interface
- `BALLS`, 3: balls per game, legal 1..3.
- `DELAY_CYCLES`, 200_000_000: newball/over hold time in `clk` cycles, ≥2 (2 s at 100 MHz).
- `clk`  in  1  system clock; all inputs are synchronous to it.
- `rstn`  in  1  reset, asynchronous, active-low.
- `start_key`  in  1  level; high while the start key (space) is held.
- `hit`  in  1  level from `pong_graph`; a rising edge is one brick/paddle hit.
- `miss`  in  1  level from `pong_graph`; a rising edge is one lost ball.
- `gra_still`  out  1  freeze playfield; high in every state except PLAY.
- `game_reset`  out  1  one-cycle pulse when a new game starts; rebuilds the bricks.
- `state`  out  2  current FSM state.
- `balls`  out  2  balls remaining, unsigned.
- `score_bcd`  out  16  current score, 4 BCD digits, msd at [15:12].
- `hi_bcd`  out  16  high score, 4 BCD digits.
- `seg_data`  out  32  `{hi_bcd, score_bcd}`, wired directly to `Seg7Device`.

## Operation
- Edge detect: `hit`, `miss` and `start_key` are each registered once. An event is `x & ~x_q`, so an input held high counts exactly once.
- States (2-bit encoding): NEWGAME=00, PLAY=01, NEWBALL=10, OVER=11.
- NEWGAME
  - `gra_still`=1.
  - On a start edge: score:=0, balls:=BALLS, pulse `game_reset`, go to PLAY.
- PLAY
  - `gra_still`=0.
  - Hit edge: score +1 in BCD (digit carry 9→0). Saturates at 9999; no wrap.
  - Miss edge with balls>1: balls −1, load timer, go to NEWBALL.
  - Miss edge with balls==1: balls:=0, load timer, go to OVER.
  - Hit and miss in the same cycle: both are applied; the score increments and the miss transition is taken.
- NEWBALL
  - Timer counts down from DELAY_CYCLES−1.
  - When the timer reaches 0, go to PLAY. Start edges are ignored.
  - Hit/miss edges in NEWBALL and OVER are ignored.
- OVER
  - On the entry cycle, if score > hi then hi:=score. A plain 16-bit unsigned compare is valid because the value is BCD.
  - Start edges are ignored until the timer reaches 0.
  - After expiry, a start edge takes the NEWGAME start path directly (score clear, balls load, `game_reset` pulse, PLAY).
- `score_bcd` holds its last value in NEWGAME and OVER until the next start. Score digits are never outside 0..9.

## Timing
- Reset values:
  - state=NEWGAME, `gra_still`=1, `game_reset`=0.
  - score=0000, hi=0000, balls=BALLS, timer=0.
  - All edge-detect registers=0, so an input already high when reset is released does not count as an edge.
- Latency: an input first sampled high at clock edge k updates the registered outputs at edge k. They are visible after edge k; no additional pipeline stage.
- `game_reset` is high for exactly the one cycle following the accepting edge. It coincides with the first PLAY cycle.
- NEWBALL lasts exactly DELAY_CYCLES cycles; `gra_still` drops on the next cycle.
- The hi update in OVER is visible on the first OVER cycle + 1.
- Reset mid-operation: asynchronous and immediate. It clears everything, including hi. No partial update completes.

## Structure
- Shared package `breakout_pkg`:
  - state encoding constants (NEWGAME/PLAY/NEWBALL/OVER);
  - BCD digit width constant.
  - `pong_graph` and the top level use the same constants.
- Sub-module `bcd_counter4`: 4-digit BCD incrementer with synchronous clear, increment enable and saturation at 9999. Instantiated once, for the score.
- Timer, edge detectors, FSM and hi register stay in `breakout_game_ctrl`.

## Test plan
Simulation uses DELAY_CYCLES=8, BALLS=3.
- Reset, then a start pulse → `game_reset` high for 1 cycle; state=01, balls=3, score=0000, `gra_still`=0.
- 12 single-cycle hit pulses → score_bcd=16'h0012. `hit` held high for 50 cycles → +1 only.
- Miss in PLAY → balls=2, state=10, `gra_still`=1 for exactly 8 cycles, then state=01. A hit and a start during the hold → ignored.
- Score preloaded to 9998, then 3 hits → 9999 (saturated).
- Three misses with score 0042 → state=11, balls=0, hi=0042. Start before 8 cycles → ignored; start after → new game, score 0000, hi stays 0042. A second game ending at 0017 → hi stays 0042.
- Hit and miss on the same cycle with balls=1 → score +1, state=11. `rstn` low mid-PLAY → all outputs return to their reset values immediately.
